// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the core ALU and the instruction decoder.
package alu_pkg;

  localparam int unsigned WORD     = 32;
  localparam int unsigned OP_WIDTH = 4;

  // Opcode values; cast to the opcode width at the point of use
  localparam int unsigned OP_SUM  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 5;
  localparam int unsigned OP_SRL  = 6;
  localparam int unsigned OP_SRA  = 7;
  localparam int unsigned OP_SLT  = 8;
  localparam int unsigned OP_SLTU = 9;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
// cf is the carry-out for add and the borrow (inverted carry-out) for sub.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cf
);

  logic [WIDTH-1:0] b_eff;
  logic             carry;

  always_comb begin
    b_eff = i_sub ? ~i_b : i_b;
    {carry, o_sum} = {1'b0, i_a} + {1'b0, b_eff} + (WIDTH + 1)'(i_sub);
    o_cf = i_sub ? ~carry : carry;
  end

endmodule

// File: rtl/alu.sv
// Single-cycle integer ALU: combinational result/zero/carry plus a status
// register that captures the flags of the last enabled operation.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD,
  parameter int unsigned OP_WIDTH = alu_pkg::OP_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  input  logic [OP_WIDTH-1:0] i_opcode,
  input  logic                i_flag_we,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_zero,
  output logic                o_cf,
  output logic                o_zero_q,
  output logic                o_cf_q
);

  localparam int unsigned SH_WIDTH = $clog2(WIDTH);

  logic                sub;
  logic [WIDTH-1:0]    addsub_sum;
  logic                addsub_cf;
  logic [SH_WIDTH-1:0] sh;
  logic                slt;

  // SUB, SLT and SLTU all reuse the subtractor's borrow
  assign sub = (i_opcode == OP_WIDTH'(OP_SUB)) ||
               (i_opcode == OP_WIDTH'(OP_SLT)) ||
               (i_opcode == OP_WIDTH'(OP_SLTU));
  assign sh  = i_b[SH_WIDTH-1:0];
  // Signed less-than: differing signs decide directly, otherwise the borrow does
  assign slt = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) ? i_a[WIDTH-1] : addsub_cf;

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_sub (sub),
    .i_a   (i_a),
    .i_b   (i_b),
    .o_sum (addsub_sum),
    .o_cf  (addsub_cf)
  );

  always_comb begin
    o_result = '0;
    o_cf     = 1'b0;
    case (i_opcode)
      OP_WIDTH'(OP_SUM),
      OP_WIDTH'(OP_SUB): begin
        o_result = addsub_sum;
        o_cf     = addsub_cf;
      end
      OP_WIDTH'(OP_AND):  o_result = i_a & i_b;
      OP_WIDTH'(OP_OR):   o_result = i_a | i_b;
      OP_WIDTH'(OP_XOR):  o_result = i_a ^ i_b;
      OP_WIDTH'(OP_SLL):  o_result = i_a << sh;
      OP_WIDTH'(OP_SRL):  o_result = i_a >> sh;
      OP_WIDTH'(OP_SRA):  o_result = WIDTH'($signed(i_a) >>> sh);
      OP_WIDTH'(OP_SLT):  o_result = WIDTH'(slt);
      OP_WIDTH'(OP_SLTU): o_result = WIDTH'(addsub_cf);
      default: begin
        o_result = '0;
        o_cf     = 1'b0;
      end
    endcase
    o_zero = (o_result == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_zero_q <= 1'b0;
      o_cf_q   <= 1'b0;
    end else if (i_flag_we) begin
      o_zero_q <= o_zero;
      o_cf_q   <= o_cf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU datapath and its status register.
module tb_alu;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         flag_we;
  logic [W-1:0] result;
  logic         zero;
  logic         cf;
  logic         zero_q;
  logic         cf_q;

  int tests;
  int fails;

  alu #(
    .WIDTH    (W),
    .OP_WIDTH (4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a       (a),
    .i_b       (b),
    .i_opcode  (opcode),
    .i_flag_we (flag_we),
    .o_result  (result),
    .o_zero    (zero),
    .o_cf      (cf),
    .o_zero_q  (zero_q),
    .o_cf_q    (cf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one combinational vector and check result, zero and cf
  task automatic vec(input string tag, input logic [3:0] op, input logic [W-1:0] va,
                     input logic [W-1:0] vb, input logic [W-1:0] exp_res,
                     input logic exp_zero, input logic exp_cf);
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
    #1;
    check_eq({tag, ".result"}, result, exp_res);
    check_eq({tag, ".zero"}, W'(zero), W'(exp_zero));
    check_eq({tag, ".cf"}, W'(cf), W'(exp_cf));
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    flag_we = 1'b0;
    a       = '0;
    b       = '0;
    opcode  = 4'd0;
    #2;
    check_eq("reset.zero_q", W'(zero_q), 32'd0);
    check_eq("reset.cf_q", W'(cf_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("sum_3_4",   4'd0, 32'd3,        32'd4,  32'd7,        1'b0, 1'b0);
    vec("sum_wrap",  4'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b1, 1'b1);
    vec("sub_5_3",   4'd1, 32'd5,        32'd3,  32'd2,        1'b0, 1'b0);
    vec("sub_3_5",   4'd1, 32'd3,        32'd5,  32'hFFFFFFFE, 1'b0, 1'b1);
    vec("sub_1_1",   4'd1, 32'd1,        32'd1,  32'd0,        1'b1, 1'b0);
    vec("and",       4'd2, 32'hF0,       32'hAA, 32'hA0,       1'b0, 1'b0);
    vec("or",        4'd3, 32'hF0,       32'h0F, 32'hFF,       1'b0, 1'b0);
    vec("xor",       4'd4, 32'hF0,       32'hAA, 32'h5A,       1'b0, 1'b0);
    vec("sll_31",    4'd5, 32'd1,        32'd31, 32'h80000000, 1'b0, 1'b0);
    vec("sll_hib",   4'd5, 32'd1,        32'd35, 32'd8,        1'b0, 1'b0);
    vec("srl_4",     4'd6, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 1'b0);
    vec("sra_4",     4'd7, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 1'b0);
    vec("sra_pos",   4'd7, 32'h40000000, 32'd4,  32'h04000000, 1'b0, 1'b0);
    vec("slt_neg",   4'd8, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b0, 1'b0);
    vec("slt_pos",   4'd8, 32'd5,        32'd3,  32'd0,        1'b1, 1'b0);
    vec("sltu",      4'd9, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b1, 1'b0);
    vec("sltu_lt",   4'd9, 32'd3,        32'd5,  32'd1,        1'b0, 1'b0);
    vec("op15",      4'd15, 32'hFFFFFFFF, 32'd1, 32'd0,        1'b1, 1'b0);
    vec("op10",      4'd10, 32'h12345678, 32'd9, 32'd0,        1'b1, 1'b0);

    // Capture SUB 1-1 flags
    @(negedge clk);
    opcode = 4'd1; a = 32'd1; b = 32'd1; flag_we = 1'b1;
    @(posedge clk); #1;
    check_eq("we1.zero_q", W'(zero_q), 32'd1);
    check_eq("we1.cf_q", W'(cf_q), 32'd0);

    // Disabled capture must hold even though cf now differs
    @(negedge clk);
    opcode = 4'd0; a = 32'hFFFFFFFF; b = 32'd1; flag_we = 1'b0;
    @(posedge clk); #1;
    check_eq("hold.zero_q", W'(zero_q), 32'd1);
    check_eq("hold.cf_q", W'(cf_q), 32'd0);

    @(negedge clk);
    flag_we = 1'b1;
    @(posedge clk); #1;
    check_eq("we2.zero_q", W'(zero_q), 32'd1);
    check_eq("we2.cf_q", W'(cf_q), 32'd1);

    @(negedge clk);
    opcode = 4'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check_eq("we3.zero_q", W'(zero_q), 32'd0);
    check_eq("we3.cf_q", W'(cf_q), 32'd0);

    // Set both flags again, then reset asynchronously between edges
    @(negedge clk);
    opcode = 4'd0; a = 32'hFFFFFFFF; b = 32'd1;
    @(posedge clk); #2;
    check_eq("pre_rst.cf_q", W'(cf_q), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst.zero_q", W'(zero_q), 32'd0);
    check_eq("async_rst.cf_q", W'(cf_q), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    flag_we = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst.zero_q", W'(zero_q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
